// File: rtl/uart_byte_rx.sv
// UART byte receiver: 2-flop line synchroniser, mid-bit sampling, optional parity,
// 1 or 2 stop bits. Good bytes update o_data with a one-cycle o_valid pulse; parity and
// framing faults give a one-cycle o_error pulse and leave o_data untouched.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUD_RATE  = 9_600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_BIT = 0,
  parameter int unsigned ODD_PARITY = 1,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_error,
  output logic                 o_busy
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned MidBit     = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned IdxW       = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_ok_q, par_ok_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 bit_mid, bit_end;

  // Counter reaches the middle of the start bit, then re-phased so every later
  // full-period wrap lands mid-bit.
  assign bit_mid = (cnt_q == CntW'(MidBit));
  assign bit_end = (cnt_q == CntW'(ClksPerBit - 1));

  // Two-flop synchroniser for the asynchronous serial line (idle high).
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame state, counters and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_ok_q   <= 1'b1;
      stop_bad_q <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_ok_q   <= par_ok_d;
      stop_bad_q <= stop_bad_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: walk the frame, decide the outcome on the last stop sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_ok_d   = par_ok_q;
    stop_bad_d = stop_bad_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) begin
          state_d    = StStart;
          par_ok_d   = 1'b1;
          stop_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_mid) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_BIT != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d    = '0;
          par_ok_d = ((^shift_q) ^ rx_s_q) == (ODD_PARITY != 0);
          state_d  = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (stop_bad_q || !rx_s_q) begin
              // Framing fault: hold off until the line recovers to avoid error storms.
              error_d = 1'b1;
              state_d = StBreak;
            end else if (!par_ok_q) begin
              error_d = 1'b1;
              state_d = StIdle;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
              state_d = StIdle;
            end
          end else begin
            idx_d      = idx_q + IdxW'(1);
            stop_bad_d = stop_bad_q | ~rx_s_q;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_error = error_q;
  assign o_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: an 8N1 instance and an 8-odd-parity, 2-stop instance.
// Each sent frame queues its expected outcome (kind, byte, pulse cycle); one compare
// process checks both instances every cycle against that queue.
module tb_uart_byte_rx;

  localparam int ClkFreq = 1_000_000;
  localparam int Baud    = 100_000;
  localparam int Cpb     = ClkFreq / Baud;
  localparam int Mid     = Cpb / 2;
  // Sync (2) + idle detect (1) + start count to mid (Mid+1) from the cycle the line falls.
  localparam int Lead    = 4 + Mid;

  typedef struct {
    int   cyc;
    logic err;
    logic brk;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_a = 1'b1;
  logic rx_p = 1'b1;
  logic [7:0] data_a, data_p;
  logic valid_a, error_a, busy_a;
  logic valid_p, error_p, busy_p;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q_a[$];
  exp_t q_p[$];
  logic [7:0] model [2];
  int nv [2];
  int ne [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_rx #(
    .CLK_FREQ  (ClkFreq),
    .BAUD_RATE (Baud)
  ) dut_a (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_rx    (rx_a),
    .o_data  (data_a),
    .o_valid (valid_a),
    .o_error (error_a),
    .o_busy  (busy_a)
  );

  uart_byte_rx #(
    .CLK_FREQ   (ClkFreq),
    .BAUD_RATE  (Baud),
    .PARITY_BIT (1),
    .ODD_PARITY (1),
    .STOP_BITS  (2)
  ) dut_p (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_rx    (rx_p),
    .o_data  (data_p),
    .o_valid (valid_p),
    .o_error (error_p),
    .o_busy  (busy_p)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int ch, input logic v);
    if (ch == 0) rx_a = v;
    else rx_p = v;
  endtask

  task automatic idle(input int ch, input int n);
    set_line(ch, 1'b1);
    repeat (n) tick();
  endtask

  // Drive one frame; the line is left at the last stop-bit level.
  task automatic send_frame(input int ch, input logic [7:0] d, input logic par_flip,
                            input logic [1:0] stop_bad);
    logic bits[$];
    exp_t x;
    int nstop;
    logic framing;
    nstop = (ch == 0) ? 1 : 2;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (ch == 1) bits.push_back(~(^d) ^ par_flip);
    framing = 1'b0;
    for (int s = 0; s < nstop; s++) begin
      bits.push_back(~stop_bad[s]);
      framing = framing | stop_bad[s];
    end
    x.cyc  = cyc + Lead + (bits.size() - 1) * Cpb;
    x.err  = framing | ((ch == 1) && par_flip);
    x.brk  = framing;
    x.data = d;
    if (ch == 0) q_a.push_back(x);
    else q_p.push_back(x);
    for (int i = 0; i < bits.size(); i++) begin
      set_line(ch, bits[i]);
      repeat (Cpb) tick();
    end
  endtask

  task automatic check_ch(input int ch, input logic v, input logic e, input logic [7:0] d,
                          input logic b);
    exp_t h;
    exp_t dummy;
    int n;
    n = (ch == 0) ? q_a.size() : q_p.size();
    if (n > 0) begin
      if (ch == 0) h = q_a[0];
      else h = q_p[0];
    end
    chk($sformatf("ch%0d_valid_error_exclusive", ch), {31'd0, v & e}, 32'd0);
    if (v || e) begin
      if (n == 0) begin
        chk($sformatf("ch%0d_unexpected_pulse_ve", ch), {30'd0, v, e}, 32'd0);
      end else begin
        chk($sformatf("ch%0d_pulse_cycle", ch), cyc, h.cyc);
        chk($sformatf("ch%0d_pulse_is_error", ch), {31'd0, e}, {31'd0, h.err});
        if (!h.err) model[ch] = h.data;
        if (!h.brk) chk($sformatf("ch%0d_busy_at_pulse", ch), {31'd0, b}, 32'd0);
        if (ch == 0) dummy = q_a.pop_front();
        else dummy = q_p.pop_front();
      end
      if (v) nv[ch]++;
      if (e) ne[ch]++;
    end else if (n > 0 && cyc > h.cyc) begin
      chk($sformatf("ch%0d_missing_pulse_cycle", ch), cyc, h.cyc);
      if (ch == 0) dummy = q_a.pop_front();
      else dummy = q_p.pop_front();
    end
    chk($sformatf("ch%0d_data", ch), {24'd0, d}, {24'd0, model[ch]});
  endtask

  // Per-cycle comparison of both instances against the expectation queues.
  always @(negedge clk) begin
    if (rst_n) begin
      check_ch(0, valid_a, error_a, data_a, busy_a);
      check_ch(1, valid_p, error_p, data_p, busy_p);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data_a"}, {24'd0, data_a}, 32'd0);
    chk({tag, "_data_p"}, {24'd0, data_p}, 32'd0);
    chk({tag, "_flags_a"}, {29'd0, valid_a, error_a, busy_a}, 32'd0);
    chk({tag, "_flags_p"}, {29'd0, valid_p, error_p, busy_p}, 32'd0);
  endtask

  task automatic apply_reset();
    exp_t dummy;
    while (q_a.size() > 0) dummy = q_a.pop_front();
    while (q_p.size() > 0) dummy = q_p.pop_front();
    model[0] = 8'h00;
    model[1] = 8'h00;
    rx_a  = 1'b1;
    rx_p  = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int v0, e0;
    logic [7:0] d;
    logic pf;
    logic [1:0] sb;
    int ch;
    model[0] = 8'h00;
    model[1] = 8'h00;
    nv[0] = 0; nv[1] = 0; ne[0] = 0; ne[1] = 0;

    #2;
    apply_reset();

    // 1: plain frame
    send_frame(0, 8'h2A, 1'b0, 2'b00);
    idle(0, 10);
    chk("t1_valid_count", nv[0], 1);
    chk("t1_error_count", ne[0], 0);
    chk("t1_data", {24'd0, data_a}, 32'h2A);
    chk("t1_busy_low", {31'd0, busy_a}, 32'd0);

    // 2: false start, 3-cycle glitch
    set_line(0, 1'b0);
    repeat (3) tick();
    set_line(0, 1'b1);
    repeat (3) tick();
    chk("t2_busy_during_start", {31'd0, busy_a}, 32'd1);
    repeat (20) tick();
    chk("t2_busy_low", {31'd0, busy_a}, 32'd0);
    chk("t2_valid_count", nv[0], 1);
    chk("t2_error_count", ne[0], 0);
    chk("t2_data", {24'd0, data_a}, 32'h2A);

    // 3: framing error, long break, recovery
    send_frame(0, 8'h55, 1'b0, 2'b01);
    repeat (40) tick();
    chk("t3_error_count", ne[0], 1);
    chk("t3_busy_in_break", {31'd0, busy_a}, 32'd1);
    chk("t3_data_held", {24'd0, data_a}, 32'h2A);
    idle(0, 20);
    chk("t3_busy_after_break", {31'd0, busy_a}, 32'd0);
    send_frame(0, 8'h07, 1'b0, 2'b00);
    idle(0, 10);
    chk("t3_data_new", {24'd0, data_a}, 32'h07);
    chk("t3_valid_count", nv[0], 2);

    // 4: odd parity good then bad
    send_frame(1, 8'h03, 1'b0, 2'b00);
    idle(1, 10);
    chk("t4_data_good", {24'd0, data_p}, 32'h03);
    chk("t4_valid_count", nv[1], 1);
    send_frame(1, 8'h03, 1'b1, 2'b00);
    idle(1, 10);
    chk("t4_error_count", ne[1], 1);
    chk("t4_data_held", {24'd0, data_p}, 32'h03);
    chk("t4_busy_low", {31'd0, busy_p}, 32'd0);

    // 5: back-to-back frames
    v0 = nv[0];
    send_frame(0, 8'h00, 1'b0, 2'b00);
    send_frame(0, 8'hFF, 1'b0, 2'b00);
    idle(0, 10);
    chk("t5_valid_count", nv[0] - v0, 2);
    chk("t5_data", {24'd0, data_a}, 32'hFF);

    // 6: reset in the middle of a data phase
    set_line(0, 1'b0);
    repeat (Cpb) tick();
    for (int i = 0; i < 4; i++) begin
      set_line(0, ((8'hA5 >> i) & 8'h01) != 8'h00);
      repeat (Cpb) tick();
    end
    apply_reset();
    send_frame(0, 8'h5A, 1'b0, 2'b00);
    idle(0, 10);
    chk("t6_data", {24'd0, data_a}, 32'h5A);

    // Random frames on both instances with occasional parity/framing faults.
    for (int k = 0; k < 60; k++) begin
      ch = k % 2;
      d  = 8'($urandom);
      pf = (ch == 1) && ($urandom_range(0, 4) == 0);
      sb = 2'b00;
      if ($urandom_range(0, 5) == 0) sb = (ch == 0) ? 2'b01 : 2'($urandom_range(1, 3));
      v0 = nv[ch];
      e0 = ne[ch];
      send_frame(ch, d, pf, sb);
      if (sb != 2'b00) idle(ch, $urandom_range(4, 20));
      else idle(ch, $urandom_range(0, 12));
    end
    idle(0, 2 * Cpb);
    idle(1, 2 * Cpb);
    chk("end_queue_a_empty", q_a.size(), 0);
    chk("end_queue_p_empty", q_p.size(), 0);
    chk("end_busy", {30'd0, busy_a, busy_p}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
